// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
`timescale 1ns/1ps
package ifetch_pkg;

    // Fetch sequencing state: normal fetching, or waiting for stale responses.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifetch_state_e;

    // One instruction-buffer entry: the fetched word and the PC it came from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ifetch_entry_t;

    // Canonical RISC-V NOP (addi x0, x0, 0); used as the buffer's idle contents.
    localparam logic [31:0] IFETCH_NOP = 32'h0000_0013;

    // Word-align an address by clearing its two low bits.
    function automatic logic [31:0] ifetch_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order instruction buffer: power-of-two depth ring with push, pop,
// flush, full/empty flags and an occupancy count. Simultaneous push and
// pop is accepted even when full, keeping occupancy constant.
`timescale 1ns/1ps
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  ifetch_entry_t        wdata_i,
    input  logic                 pop_i,
    output ifetch_entry_t        rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_W-1:0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    ifetch_entry_t      mem_q [DEPTH];
    ifetch_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Next pointers, occupancy and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers; storage resets to NOPs so the head is benign.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{inst: IFETCH_NOP, pc: 32'h0000_0000};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches, tracks in-flight
// grants, buffers in-order responses and handles redirects by flushing and
// draining stale responses.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN -- when defined, a redirect
// target with nonzero low bits raises a sticky fetch_err_o.
`timescale 1ns/1ps
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_pc_four_o,
    input  logic        inst_ready_i,
    output logic        fetch_err_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    ifetch_state_e      state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [CNT_W:0]     inflight_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    ifetch_entry_t      fifo_rdata_s;
    ifetch_entry_t      fifo_wdata_s;
    logic               req_s;
    logic               gnt_s;
    logic               rvalid_s;
    logic               push_s;
    logic               pop_s;
    logic [31:0]        target_s;

    // Low target bits are dropped in both builds; only the flag is optional.
    assign target_s     = ifetch_align(redirect_pc_i);
    assign inflight_s   = {1'b0, out_q} + {1'b0, fifo_count_s};
    assign gnt_s        = req_s && imem_gnt_i;
    assign rvalid_s     = imem_rvalid_i && (out_q != {CNT_W{1'b0}});
    assign push_s       = rvalid_s && (state_q == RUN) && !redirect_i;
    assign pop_s        = !fifo_empty_s && inst_ready_i && !redirect_i;
    assign fifo_wdata_s = '{inst: imem_rdata_i, pc: resp_pc_q};

    assign imem_req_o     = req_s;
    assign imem_addr_o    = pc_q;
    assign inst_valid_o   = !fifo_empty_s;
    assign inst_o         = fifo_rdata_s.inst;
    assign inst_pc_o      = fifo_rdata_s.pc;
    assign inst_pc_four_o = fifo_rdata_s.pc + 32'd4;

    // Request only when a buffer slot is reserved for every in-flight word;
    // a redirect masks the request in the same cycle, as does reset.
    always_comb begin
        req_s = 1'b0;
        if (!rst_i && !redirect_i && (state_q == RUN) && !fifo_full_s &&
            (inflight_s < (CNT_W + 1)'(BUF_DEPTH))) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Outstanding-grant counter, fetch PC, response PC and fetch state.
    always_comb begin
        out_d     = out_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        state_d   = state_q;
        case ({gnt_s, rvalid_s})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase
        if (redirect_i) begin
            // Every response still in flight belongs to the old path, so the
            // next pushed word is the first one fetched from the new target.
            pc_d      = target_s;
            resp_pc_d = target_s;
            if (out_d != {CNT_W{1'b0}}) begin
                state_d = DRAIN;
            end else begin
                state_d = RUN;
            end
        end else begin
            if (gnt_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            case (state_q)
                RUN:     state_d = RUN;
                DRAIN: begin
                    if (out_d == {CNT_W{1'b0}}) begin
                        state_d = RUN;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Fetch sequencing registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic err_q, err_d;

    // Sticky misalignment flag; only reset clears it.
    always_comb begin
        err_d = err_q;
        if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Misalignment flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign fetch_err_o = 1'b0;
`endif

    ifetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus pushes expected fetch
// addresses and instruction PCs; a monitor pops and compares them whenever
// the DUT grants a fetch or hands an instruction to decode.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_pc_four_o;
    logic        inst_ready = 1'b1;
    logic        fetch_err_o;

`ifdef IFETCH_MISALIGN_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_inst[$];
    int          budget = 0;
    int          lat = 1;
    int          grants = 0;
    int          cyc = 0;
    logic        gnt_force = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_pc_four_o (inst_pc_four_o),
        .inst_ready_i   (inst_ready),
        .fetch_err_o    (fetch_err_o)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] base, input int n, input bit with_inst);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(base + 32'(4 * i));
            if (with_inst) exp_inst.push_back(base + 32'(4 * i));
        end
        budget = budget + n;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            #3;
            if (budget == 0 && pend.size() == 0 && !imem_rvalid_i &&
                exp_addr.size() == 0 && exp_inst.size() == 0 && !inst_valid_o)
                done = 1'b1;
        end
        chk({nm, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic drain_check(input string nm, input logic [31:0] tgt);
        for (int i = 0; i < 20 && (pend.size() > 0 || imem_rvalid_i); i++) begin
            #3;
            chk({nm, "_req_in_drain"}, 32'(imem_req_o), 32'd0);
            step();
        end
        #3;
        chk({nm, "_req_after_drain"}, 32'(imem_req_o), 32'd1);
        chk({nm, "_addr_after_drain"}, imem_addr_o, tgt);
    endtask

    // Memory model: in-order responses `lat` cycles after each grant.
    always begin
        @(negedge clk);
        cyc = cyc + 1;
        imem_gnt_i = (budget > 0) || gnt_force;
        if (rst) begin
            pend.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else if (pend.size() > 0 && pend[0].due <= 32'(cyc)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
        end
        #4;
        if (!rst && imem_req_o && imem_gnt_i) begin
            pend.push_back('{addr: imem_addr_o, due: 32'(cyc + lat)});
            grants = grants + 1;
            if (budget > 0) budget = budget - 1;
        end
    end

    // Monitor: compare every granted fetch and every decode handshake.
    always begin
        @(negedge clk);
        #6;
        if (!rst) begin
            if (imem_req_o && imem_gnt_i) begin
                if (exp_addr.size() == 0) chk("unexpected_grant", imem_addr_o, 32'hFFFF_FFFF);
                else chk("fetch_addr", imem_addr_o, exp_addr.pop_front());
            end
            if (inst_valid_o && inst_ready && !redirect) begin
                if (exp_inst.size() == 0) begin
                    chk("unexpected_inst", inst_pc_o, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] p;
                    p = exp_inst.pop_front();
                    chk("inst_pc", inst_pc_o, p);
                    chk("inst_data", inst_o, mem_word(p));
                    chk("inst_pc_four", inst_pc_four_o, p + 32'd4);
                end
            end
        end
    end

    initial begin
        int g0;
        bit seen;

        // Reset state.
        repeat (3) step();
        #3;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);

        // Sequential fetch with gnt=1, latency 1, ready=1.
        issue(32'h0, 3, 1'b1);
        step();
        rst = 1'b0;
        #3;
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        step();
        step();
        #3;
        chk("c3_valid", 32'(inst_valid_o), 32'd1);
        chk("c3_pc", inst_pc_o, 32'h0);
        chk("c3_pc_four", inst_pc_four_o, 32'h4);
        wait_idle("seq");

        // Decode stalled for 10 cycles: only two words may be in flight/buffered.
        inst_ready = 1'b0;
        g0 = grants;
        issue(32'h0000_000C, 10, 1'b1);
        repeat (10) step();
        #3;
        chk("stall_grants", 32'(grants - g0), 32'd2);
        chk("stall_req", 32'(imem_req_o), 32'd0);
        chk("stall_valid", 32'(inst_valid_o), 32'd1);
        chk("stall_head_pc", inst_pc_o, 32'h0000_000C);
        inst_ready = 1'b1;
        wait_idle("stall");

        // Redirect to 0x100 with two responses outstanding.
        lat = 4;
        g0 = grants;
        issue(32'h0000_0034, 2, 1'b0);
        for (int i = 0; i < 20 && grants < g0 + 2; i++) step();
        chk("rd1_grants", 32'(grants - g0), 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        lat = 1;
        issue(32'h0000_0100, 2, 1'b1);
        #3;
        chk("rd1_req_masked", 32'(imem_req_o), 32'd0);
        step();
        redirect = 1'b0;
        drain_check("rd1", 32'h0000_0100);
        wait_idle("rd1");

        // Two redirects during drain: the last one wins.
        lat = 4;
        g0 = grants;
        issue(32'h0000_0108, 2, 1'b0);
        for (int i = 0; i < 20 && grants < g0 + 2; i++) step();
        chk("rd2_grants", 32'(grants - g0), 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_pc = 32'h0000_0300;
        lat = 1;
        issue(32'h0000_0300, 1, 1'b1);
        step();
        redirect = 1'b0;
        drain_check("rd2", 32'h0000_0300);
        wait_idle("rd2");

        // Misaligned redirect from idle while the memory offers a grant.
        gnt_force = 1'b1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        gnt_force = 1'b0;
        issue(32'h0000_0100, 1, 1'b1);
        #3;
        chk("mis_req_masked", 32'(imem_req_o), 32'd0);
        step();
        redirect = 1'b0;
        #3;
        chk("mis_err", 32'(fetch_err_o), 32'(ERR_EXP));
        chk("mis_addr", imem_addr_o, 32'h0000_0100);
        wait_idle("mis");
        chk("mis_err_sticky", 32'(fetch_err_o), 32'(ERR_EXP));

        // Reset in mid-fetch with a response pending.
        inst_ready = 1'b0;
        lat = 3;
        issue(32'h0000_0104, 2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            #3;
            if (inst_valid_o) seen = 1'b1;
        end
        chk("mid_valid_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req_o), 32'd0);
        chk("mid_rst_valid", 32'(inst_valid_o), 32'd0);
        chk("mid_rst_err", 32'(fetch_err_o), 32'd0);
        chk("mid_rst_addr", imem_addr_o, 32'h0);
        chk("mid_rst_exp_left", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_inst.delete();
        budget = 0;
        lat = 1;
        step();
        step();
        issue(32'h0, 1, 1'b1);
        inst_ready = 1'b1;
        step();
        rst = 1'b0;
        #3;
        chk("post_rst_req", 32'(imem_req_o), 32'd1);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        wait_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
